// File: rtl/handshake_elastic_fifo.sv
// -----------------------------------------------------------------------------
// handshake_elastic_fifo
//
// Elastic FIFO placed between single-output handshake producers (constant
// stages and similar) and their consumers. Both directions are registered:
// outs/outs_valid come straight from the storage array and occupancy
// counter, and ins_ready depends only on the occupancy counter. There is
// therefore no combinational path from any input to any output.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge
// where valid and ready are both high. The producer holds data and valid
// until the transfer happens; this FIFO holds outs/outs_valid stable while
// outs_valid=1 and outs_ready=0.
//
// Parameters
//   DATA_WIDTH  token width in bits (>= 1)
//   NUM_SLOTS   storage depth in tokens (>= 2, any value, not only 2^n)
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous active-low reset
//   ins         input token data
//   ins_valid   upstream offers a token on ins
//   ins_ready   FIFO can accept a token this cycle (not full)
//   outs        head token data (reads 0 after reset)
//   outs_valid  a head token is present (not empty)
//   outs_ready  downstream accepts the head token this cycle
//   count       current occupancy, 0..NUM_SLOTS
// -----------------------------------------------------------------------------
module handshake_elastic_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLOTS  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_WIDTH-1:0]          ins,
    input  logic                           ins_valid,
    output logic                           ins_ready,
    output logic [DATA_WIDTH-1:0]          outs,
    output logic                           outs_valid,
    input  logic                           outs_ready,
    output logic [$clog2(NUM_SLOTS+1)-1:0] count
);

    localparam int CW = $clog2(NUM_SLOTS + 1);
    localparam int PW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(NUM_SLOTS);
    localparam logic [PW-1:0] LAST_PTR = PW'(NUM_SLOTS - 1);

    logic [DATA_WIDTH-1:0] mem_q [NUM_SLOTS];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  push;
    logic                  pop;

    // Pointers wrap explicitly at NUM_SLOTS-1 so non-power-of-two depths
    // never touch slots beyond the array.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Both handshake-side outputs are decoded from the registered counter
    // only; neither looks at the opposite side's inputs.
    assign ins_ready  = (cnt_q != FULL_CNT);
    assign outs_valid = (cnt_q != '0);

    assign push = ins_valid & ins_ready;
    assign pop  = outs_valid & outs_ready;

    assign outs  = mem_q[rd_ptr_q];
    assign count = cnt_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        if (push) begin
            wr_ptr_d = ptr_next(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end

        // Simultaneous push and pop leaves the occupancy unchanged. An
        // empty FIFO cannot pop and a full one cannot push, so the counter
        // never leaves 0..NUM_SLOTS.
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage is cleared on reset so that outs reads 0 immediately after
    // reset assertion, independent of clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (push) begin
                mem_q[wr_ptr_q] <= ins;
            end
        end
    end

endmodule

// File: doc/handshake_elastic_fifo.md
# handshake_elastic_fifo

Elastic FIFO that buffers tokens produced by handshake constant stages and other single-output handshake units before they reach downstream consumers. It breaks both the valid/data path and the ready path, so there is no combinational path from input to output. It stores up to NUM_SLOTS tokens and sustains one token per cycle whenever it is neither empty-starved nor full.

## Interface
- DATA_WIDTH, 32, token width in bits; must be ≥1.
- NUM_SLOTS, 4, storage depth in tokens; must be ≥2; need not be a power of two.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset; assertion clears all state immediately; deassertion is sampled on clk.
- ins  in  DATA_WIDTH  input token data.
- ins_valid  in  1  upstream offers the token on ins.
- ins_ready  out  1  FIFO can accept a token this cycle.
- outs  out  DATA_WIDTH  head token data.
- outs_valid  out  1  head token present.
- outs_ready  in  1  downstream accepts the head token this cycle.
- count  out  $clog2(NUM_SLOTS+1)  current occupancy, 0..NUM_SLOTS.

## Operation
- Storage: NUM_SLOTS-entry register array, write pointer wr_ptr, read pointer rd_ptr, occupancy counter cnt.
- push = ins_valid & ins_ready; pop = outs_valid & outs_ready.
- On push: mem[wr_ptr] <= ins; wr_ptr advances.
- On pop: rd_ptr advances.
- Pointer wrap: a pointer at NUM_SLOTS-1 goes to 0. No power-of-two assumption.
- cnt update: +1 on push only; −1 on pop only; unchanged on both or neither.
- ins_ready = (cnt != NUM_SLOTS); it is a pure function of registered state and never depends on outs_ready.
- outs_valid = (cnt != 0), registered state only.
- outs = mem[rd_ptr]. Its value is don't-care while outs_valid=0, but it must read 0 after reset.
- count = cnt.
- Full with outs_ready=1: the pop occurs, but no push is allowed that cycle because ins_ready=0. ins_ready rises the next cycle.
- Empty with ins_valid=1: the push occurs, and there is no pop that cycle (no bypass).
- Occupancy conditions for push and pop:
  - Simultaneous push and pop are legal whenever 0 < cnt < NUM_SLOTS.
  - cnt is unchanged in that case.
  - Both pointers advance.
- Data integrity: tokens leave in acceptance order, with no loss and no duplication.
- Downstream protocol: outs and outs_valid hold stable while outs_valid=1 and outs_ready=0.
- Reset state: all mem entries 0; wr_ptr=0; rd_ptr=0; cnt=0.
- Reset mid-operation discards all stored tokens.

## Timing
- Outputs under reset: outs_valid=0, ins_ready=1, count=0, outs=0.
- Latency: a token accepted at edge N is visible on outs with outs_valid=1 in the cycle after edge N, provided the FIFO was empty.
- Throughput: 1 token/cycle in steady state when 0 < cnt < NUM_SLOTS.
- Refill from empty costs one bubble cycle.
- Full-to-accept delay: ins_ready reasserts one cycle after the first pop from the full state.
- Combinational paths: none from ins, ins_valid, or outs_ready to any output.
- Reset assertion: asynchronous; outputs reach their reset values without waiting for clk.

## Test plan
- Reset and single token, DATA_WIDTH=27, NUM_SLOTS=4:
  - Release reset and check outs_valid=0, ins_ready=1, count=0.
  - Push 27'h7C8CDD5 for one cycle: outs=27'h7C8CDD5 and outs_valid=1 in the next cycle, count=1.
  - Pop it: count=0 and outs_valid=0 in the following cycle.
- Fill to full with outs_ready=0:
  - Push 1,2,3,4: count=4 and ins_ready=0.
  - Hold a 5th token (5) on ins: it is not accepted.
  - Raise outs_ready: outs sequence is 1,2,3,4, then the 5th token is accepted once ins_ready returns.
- Streaming: ins_valid=1 and outs_ready=1 continuously with values 0..99.
  - After the first-token latency, one token per cycle, output 0..99 in order.
  - count stays at 1.
- Wrap-around with NUM_SLOTS=3: push/pop 10 tokens with random stalls and check in-order delivery across several pointer wraps.
- Downstream stall: with 2 tokens queued, hold outs_ready=0 for 5 cycles.
  - outs and outs_valid stay stable.
  - count stays 2.
- Reset mid-operation: with count=3, assert rst between edges.
  - outs_valid=0, count=0, ins_ready=1 immediately.
  - After release, the next pushed token (0x15) is the first one output.
